// File: rtl/uart_rx_param.sv
// uart_rx_param : oversampled UART receiver with mid-bit sampling.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx         serial input, idle high, asynchronous to clk
//   baud_tick  one-clk pulse, OVERSAMPLE pulses per bit period
//   rx_data    received word, stable while rx_valid=1
//   rx_valid   word available
//   rx_ready   consumer accepts word when rx_valid & rx_ready
//   frame_err  a stop bit was sampled 0 (qualified by rx_valid)
//   parity_err parity mismatch (qualified by rx_valid)
//   overrun    one-clk pulse: frame completed while rx_valid still 1
//
// State table
//   S_IDLE   | line idle, waiting for a low sample (only when armed)
//   S_START  | counting to the middle of the start bit
//   S_DATA   | sampling DATA_BITS data bits, LSB first
//   S_PARITY | sampling the parity bit
//   S_STOP   | sampling STOP_BITS stop bits; last sample completes the frame

module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 baud_tick,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] T_MID     = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_END     = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_ONE     = TW'(1);
   localparam logic [BW-1:0] B_LAST    = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic [BW-1:0] B_ONE     = BW'(1);
   localparam logic          ODD       = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                 state_q;
   logic                   rx_meta_q;
   logic                   rx_s_q;
   logic [TW-1:0]          tcnt_q;
   logic [BW-1:0]          bcnt_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   par_err_q;
   logic                   frm_err_q;
   logic                   armed_q;
   logic                   done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Receive FSM. Every decision is taken on a baud_tick; done_q marks the
   // tick that sampled the final stop bit and feeds the output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         tcnt_q    <= '0;
         bcnt_q    <= '0;
         shift_q   <= '0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
         armed_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (baud_tick) begin
            case (state_q)
               S_IDLE: begin
                  // After a framing error the line must be seen high once
                  // before a new start bit is accepted (break handling).
                  if (rx_s_q) begin
                     armed_q <= 1'b1;
                  end else if (armed_q) begin
                     state_q <= S_START;
                     tcnt_q  <= '0;
                  end
               end
               S_START: begin
                  if (tcnt_q == T_MID) begin
                     tcnt_q <= '0;
                     bcnt_q <= '0;
                     if (!rx_s_q) begin
                        state_q   <= S_DATA;
                        par_err_q <= 1'b0;
                        frm_err_q <= 1'b0;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end else begin
                     tcnt_q <= tcnt_q + T_ONE;
                  end
               end
               S_DATA: begin
                  if (tcnt_q == T_END) begin
                     tcnt_q  <= '0;
                     shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                     if (bcnt_q == B_LAST) begin
                        bcnt_q <= '0;
                        if (PARITY_EN != 0) begin
                           state_q <= S_PARITY;
                        end else begin
                           state_q <= S_STOP;
                        end
                     end else begin
                        bcnt_q <= bcnt_q + B_ONE;
                     end
                  end else begin
                     tcnt_q <= tcnt_q + T_ONE;
                  end
               end
               S_PARITY: begin
                  if (tcnt_q == T_END) begin
                     tcnt_q    <= '0;
                     bcnt_q    <= '0;
                     par_err_q <= ^{shift_q, rx_s_q, ODD};
                     state_q   <= S_STOP;
                  end else begin
                     tcnt_q <= tcnt_q + T_ONE;
                  end
               end
               S_STOP: begin
                  if (tcnt_q == T_END) begin
                     tcnt_q    <= '0;
                     frm_err_q <= frm_err_q | ~rx_s_q;
                     if (bcnt_q == STOP_LAST) begin
                        // Back to IDLE right at mid-stop so a start edge
                        // half a bit later is still caught.
                        bcnt_q  <= '0;
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                        if (frm_err_q || !rx_s_q) begin
                           armed_q <= 1'b0;
                        end
                     end else begin
                        bcnt_q <= bcnt_q + B_ONE;
                     end
                  end else begin
                     tcnt_q <= tcnt_q + T_ONE;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  tcnt_q  <= '0;
                  bcnt_q  <= '0;
               end
            endcase
         end
      end
   end

   // Output stage: a completed frame is loaded when the holding register is
   // empty or being consumed in the same cycle; otherwise it is dropped and
   // overrun pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (done_q) begin
            if (!rx_valid || rx_ready) begin
               rx_data    <= shift_q;
               frame_err  <= frm_err_q;
               parity_err <= par_err_q;
               rx_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;

   localparam int TP = 3;   // clocks per baud_tick
   localparam int DB = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic baud_tick = 1'b0;
   logic rx_a = 1'b1, rx_b = 1'b1;
   logic rdy_a = 1'b1, rdy_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic val_a, val_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

   // dut_a: 8N1, OVERSAMPLE 16. dut_b: 8 data, even parity, 2 stop, OVERSAMPLE 8.
   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .rx(rx_a), .baud_tick(baud_tick),
      .rx_data(data_a), .rx_valid(val_a), .rx_ready(rdy_a),
      .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .rx(rx_b), .baud_tick(baud_tick),
      .rx_data(data_b), .rx_valid(val_b), .rx_ready(rdy_b),
      .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

   always #5 clk = ~clk;

   initial begin
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         c = (c + 1) % TP;
         baud_tick = (c == 0);
      end
   end

   int cfg_os[2]   = '{16, 8};
   int cfg_pe[2]   = '{0, 1};
   int cfg_stop[2] = '{1, 2};
   int cfg_odd[2]  = '{0, 0};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Per DUT: a frame is tracked by counting baud ticks since the start was
   // detected; sample n (0 = start) is taken OVERSAMPLE/2 + n*OVERSAMPLE
   // ticks after detection. The receiver sees rx through two flops.
   bit       m_s0[2], m_s1[2], m_busy[2], m_armed[2];
   int       m_k[2];
   bit [7:0] m_data[2];
   bit       m_pbit[2], m_ferr[2];
   bit       m_done[2];
   bit [7:0] m_dd[2];
   bit       m_df[2], m_dp[2];
   bit       e_val[2], e_fe[2], e_pe[2], e_ov[2];
   bit [7:0] e_data[2];

   task automatic model_step(input int i, input logic rxv, input logic rdy);
      bit rs;
      int half, n, os, pe, last;
      if (!rst_n) begin
         m_s0[i] = 1; m_s1[i] = 1; m_busy[i] = 0; m_armed[i] = 1; m_k[i] = 0;
         m_data[i] = 0; m_pbit[i] = 0; m_ferr[i] = 0; m_done[i] = 0;
         e_val[i] = 0; e_fe[i] = 0; e_pe[i] = 0; e_ov[i] = 0; e_data[i] = 0;
         return;
      end
      os = cfg_os[i]; pe = cfg_pe[i]; half = os / 2;
      last = DB + pe + cfg_stop[i];
      rs = m_s1[i];
      e_ov[i] = 0;
      if (m_done[i]) begin
         if (!e_val[i] || rdy) begin
            e_val[i] = 1; e_data[i] = m_dd[i]; e_fe[i] = m_df[i]; e_pe[i] = m_dp[i];
         end else begin
            e_ov[i] = 1;
         end
      end else if (e_val[i] && rdy) begin
         e_val[i] = 0;
      end
      m_done[i] = 0;
      if (baud_tick) begin
         if (!m_busy[i]) begin
            if (rs) m_armed[i] = 1;
            else if (m_armed[i]) begin
               m_busy[i] = 1; m_k[i] = 0; m_ferr[i] = 0;
            end
         end else begin
            m_k[i]++;
            if (m_k[i] == half) begin
               if (rs) m_busy[i] = 0;
            end else if (m_k[i] > half && (m_k[i] - half) % os == 0) begin
               n = (m_k[i] - half) / os;
               if (n <= DB) m_data[i][n-1] = rs;
               else if (pe != 0 && n == DB + 1) m_pbit[i] = rs;
               else begin
                  if (!rs) m_ferr[i] = 1;
                  if (n == last) begin
                     m_done[i] = 1;
                     m_dd[i] = m_data[i];
                     m_df[i] = m_ferr[i];
                     m_dp[i] = (pe != 0) ? ((^m_data[i]) ^ m_pbit[i] ^ cfg_odd[i][0]) : 1'b0;
                     m_busy[i] = 0;
                     if (m_ferr[i]) m_armed[i] = 0;
                  end
               end
            end
         end
      end
      m_s1[i] = m_s0[i];
      m_s0[i] = rxv;
   endtask

   always @(posedge clk) begin
      model_step(0, rx_a, rdy_a);
      model_step(1, rx_b, rdy_b);
   end

   // ---------------- compare + monitor ----------------
   logic       o_val[2], o_fe[2], o_pe[2], o_ov[2];
   logic [7:0] o_data[2];
   assign o_val[0] = val_a;  assign o_val[1] = val_b;
   assign o_fe[0]  = fe_a;   assign o_fe[1]  = fe_b;
   assign o_pe[0]  = pe_a;   assign o_pe[1]  = pe_b;
   assign o_ov[0]  = ov_a;   assign o_ov[1]  = ov_b;
   assign o_data[0] = data_a; assign o_data[1] = data_b;

   int       vcyc[2], ovc[2];
   bit [7:0] last_d[2];
   bit       last_fe[2], last_pe[2];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            chk("reset rx_valid", o_val[i], 0);
            chk("reset rx_data", o_data[i], 0);
            chk("reset overrun", o_ov[i], 0);
         end else begin
            chk($sformatf("rx_valid[%0d]", i), o_val[i], e_val[i]);
            chk($sformatf("overrun[%0d]", i), o_ov[i], e_ov[i]);
            if (e_val[i]) begin
               chk($sformatf("rx_data[%0d]", i), o_data[i], e_data[i]);
               chk($sformatf("frame_err[%0d]", i), o_fe[i], e_fe[i]);
               chk($sformatf("parity_err[%0d]", i), o_pe[i], e_pe[i]);
            end
         end
         if (o_val[i]) begin
            vcyc[i]++; last_d[i] = o_data[i]; last_fe[i] = o_fe[i]; last_pe[i] = o_pe[i];
         end
         if (o_ov[i]) ovc[i]++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_rx(input int i, input logic v);
      if (i == 0) rx_a = v; else rx_b = v;
   endtask

   task automatic drive(input int i, input logic v, input int nclk);
      @(negedge clk);
      set_rx(i, v);
      if (nclk > 1) repeat (nclk - 1) @(negedge clk);
   endtask

   task automatic clr_mon();
      @(posedge clk);
      vcyc = '{0, 0}; ovc = '{0, 0};
   endtask

   task automatic send_frame(input int i, input logic [7:0] d, input bit pflip,
                             input bit bad0, input bit bad1);
      int bt;
      bt = cfg_os[i] * TP;
      drive(i, 1'b0, bt);
      for (int b = 0; b < DB; b++) drive(i, d[b], bt);
      if (cfg_pe[i] != 0) drive(i, (^d) ^ cfg_odd[i][0] ^ pflip, bt);
      drive(i, !bad0, bt);
      if (cfg_stop[i] == 2) drive(i, !bad1, bt);
   endtask

   task automatic rand_frames(input int i, input int n);
      int bt;
      bt = cfg_os[i] * TP;
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            drive(i, 1'b0, $urandom_range(1, cfg_os[i] / 2 - 2) * TP);
            drive(i, 1'b1, bt);
         end else begin
            send_frame(i, 8'($urandom), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            drive(i, 1'b1, $urandom_range(1, 2 * bt));
         end
      end
   endtask

   bit rnd_rdy = 0;
   initial forever begin
      @(negedge clk);
      if (rnd_rdy) begin
         rdy_a = ($urandom_range(0, 3) != 0);
         rdy_b = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   endtask

   initial begin
      #900000;
      n_cmp++; n_bad++;
      $display("FAIL timeout: simulation did not complete within time budget");
      summary();
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] d96;
      int bta, btb;
      bta = cfg_os[0] * TP;
      btb = cfg_os[1] * TP;
      d96 = 8'h96;
      vcyc = '{0, 0}; ovc = '{0, 0};

      repeat (4) @(posedge clk);
      chk("in reset rx_valid_a", val_a, 0);
      chk("in reset rx_data_b", data_b, 0);
      #1 rst_n = 1'b1;
      drive(0, 1'b1, bta);

      // 8N1 0xA5, consumer always ready
      clr_mon();
      send_frame(0, 8'hA5, 0, 0, 0);
      drive(0, 1'b1, bta);
      chk("A5 data", last_d[0], 8'hA5);
      chk("A5 model data", e_data[0], 8'hA5);
      chk("A5 valid cycles", vcyc[0], 1);
      chk("A5 frame_err", last_fe[0], 0);
      chk("A5 parity_err", last_pe[0], 0);

      // even parity: 0x53 has four ones, so the correct parity bit is 0
      clr_mon();
      send_frame(1, 8'h53, 0, 0, 0);
      drive(1, 1'b1, btb);
      chk("53 good data", last_d[1], 8'h53);
      chk("53 good parity_err", last_pe[1], 0);
      clr_mon();
      send_frame(1, 8'h53, 1, 0, 0);
      drive(1, 1'b1, btb);
      chk("53 bad data", last_d[1], 8'h53);
      chk("53 bad parity_err", last_pe[1], 1);
      chk("53 bad model parity", e_pe[1], 1);

      // glitch shorter than half a bit, then a real frame
      clr_mon();
      drive(0, 1'b0, 4 * TP);
      drive(0, 1'b1, 2 * bta);
      chk("false start no valid", vcyc[0], 0);
      clr_mon();
      send_frame(0, 8'h3C, 0, 0, 0);
      drive(0, 1'b1, bta);
      chk("3C data", last_d[0], 8'h3C);
      chk("3C valid cycles", vcyc[0], 1);

      // overrun
      @(negedge clk) rdy_a = 1'b0;
      clr_mon();
      send_frame(0, 8'h11, 0, 0, 0);
      drive(0, 1'b1, bta);
      send_frame(0, 8'h22, 0, 0, 0);
      drive(0, 1'b1, bta);
      chk("overrun count", ovc[0], 1);
      chk("overrun model", e_data[0], 8'h11);
      chk("overrun held valid", val_a, 1);
      chk("overrun held data", data_a, 8'h11);
      @(negedge clk) rdy_a = 1'b1;
      @(negedge clk);
      chk("valid drops after accept", val_a, 0);

      // 2 stop bits, second one low, line stays low afterwards
      clr_mon();
      send_frame(1, 8'hFF, 0, 0, 1);
      drive(1, 1'b0, 2 * btb);
      chk("FF valid cycles", vcyc[1], 1);
      chk("FF data", last_d[1], 8'hFF);
      chk("FF frame_err", last_fe[1], 1);
      drive(1, 1'b1, btb);
      clr_mon();
      send_frame(1, 8'h0F, 0, 0, 0);
      drive(1, 1'b1, btb);
      chk("0F after break data", last_d[1], 8'h0F);
      chk("0F frame_err", last_fe[1], 0);
      chk("0F valid cycles", vcyc[1], 1);

      // reset in the middle of data bit 4, with an older word still held
      @(negedge clk) rdy_a = 1'b0;
      send_frame(0, 8'h5A, 0, 0, 0);
      drive(0, 1'b1, bta);
      chk("5A held", val_a, 1);
      drive(0, 1'b0, bta);
      for (int b = 0; b < 4; b++) drive(0, d96[b], bta);
      drive(0, d96[4], bta / 2);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid reset rx_valid", val_a, 0);
      chk("mid reset rx_data", data_a, 0);
      chk("mid reset frame_err", fe_a, 0);
      rdy_a = 1'b1;
      drive(0, 1'b1, bta);
      clr_mon();
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(0, 1'b1, 2 * bta);
      chk("no partial word", vcyc[0], 0);
      send_frame(0, 8'h96, 0, 0, 0);
      drive(0, 1'b1, bta);
      chk("96 data", last_d[0], 8'h96);
      chk("96 valid cycles", vcyc[0], 1);

      // randomized traffic on both receivers with random back-pressure
      rnd_rdy = 1;
      fork
         rand_frames(0, 25);
         rand_frames(1, 30);
      join
      @(posedge clk);
      rnd_rdy = 0;
      rdy_a = 1'b1;
      rdy_b = 1'b1;
      drive(0, 1'b1, 3 * bta);
      summary();
   end

endmodule
